nand_share_arbiter: RTL and testbench



---
 rtl/nand_share_arbiter.sv | 156 +++++++++++++++
 tb/tb_nand_share_arbiter.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/nand_share_arbiter.sv
// Arbitrates NREQ requesters onto one shared WIDTH-bit NAND unit (nand_21 per bit).
// Define ARB_ROUND_ROBIN_EN for round-robin arbitration; default is fixed priority.

module nand_21 (
  input  logic a,
  input  logic b,
  output logic y
);
  assign y = ~(a & b);
endmodule

module nand_share_arbiter #(
  parameter int WIDTH = 4,
  parameter int NREQ  = 4,
  parameter int PTR_W = $clog2(NREQ)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*WIDTH-1:0] op_a,
  input  logic [NREQ*WIDTH-1:0] op_b,
  output logic [NREQ-1:0]       gnt,
  output logic [NREQ-1:0]       done,
  output logic [WIDTH-1:0]      result,
  output logic                  busy
);

  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_DONE} state_t;

  state_t             state_q, state_d;
  logic [PTR_W-1:0]   id_q, id_d;
  logic [WIDTH-1:0]   opa_q, opa_d;
  logic [WIDTH-1:0]   opb_q, opb_d;
  logic [WIDTH-1:0]   result_q, result_d;
  logic [WIDTH-1:0]   nand_y;
  logic [WIDTH-1:0]   sel_a, sel_b;
  logic [PTR_W-1:0]   win;
  logic               any_req;
  logic [NREQ-1:0]    id_oh;

  assign any_req = |req;

  // Shared datapath sees only the operand registers.
  for (genvar g = 0; g < WIDTH; g++) begin : g_nand
    nand_21 u_nand (
      .a (opa_q[g]),
      .b (opb_q[g]),
      .y (nand_y[g])
    );
  end

`ifdef ARB_ROUND_ROBIN_EN
  logic [PTR_W-1:0] ptr_q, ptr_d;

  always_comb begin
    logic             found;
    logic [PTR_W-1:0] cand;
    win   = '0;
    found = 1'b0;
    cand  = '0;
    for (int unsigned k = 1; k <= unsigned'(NREQ); k++) begin
      cand = PTR_W'((32'(ptr_q) + k) % unsigned'(NREQ));
      if (!found && req[cand]) begin
        win   = cand;
        found = 1'b1;
      end
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (state_q == S_IDLE && any_req) ptr_d = win;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ptr_q <= PTR_W'(NREQ - 1);
    else        ptr_q <= ptr_d;
  end
`else
  always_comb begin
    logic             found;
    logic [PTR_W-1:0] cand;
    win   = '0;
    found = 1'b0;
    cand  = '0;
    for (int unsigned i = 0; i < unsigned'(NREQ); i++) begin
      cand = PTR_W'(i);
      if (!found && req[cand]) begin
        win   = cand;
        found = 1'b1;
      end
    end
  end
`endif

  always_comb begin
    sel_a = '0;
    sel_b = '0;
    for (int unsigned i = 0; i < unsigned'(NREQ); i++) begin
      if (PTR_W'(i) == win) begin
        sel_a = op_a[i*WIDTH +: WIDTH];
        sel_b = op_b[i*WIDTH +: WIDTH];
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    id_d     = id_q;
    opa_d    = opa_q;
    opb_d    = opb_q;
    result_d = result_q;
    unique case (state_q)
      S_IDLE: begin
        if (any_req) begin
          id_d    = win;
          opa_d   = sel_a;
          opb_d   = sel_b;
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        result_d = nand_y;
        state_d  = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      id_q     <= '0;
      opa_q    <= '0;
      opb_q    <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      id_q     <= id_d;
      opa_q    <= opa_d;
      opb_q    <= opb_d;
      result_q <= result_d;
    end
  end

  // gnt/done are decoded from state and id, so they clear with the FSM on reset.
  always_comb begin
    id_oh  = NREQ'(1) << id_q;
    busy   = (state_q != S_IDLE);
    gnt    = busy ? id_oh : '0;
    done   = (state_q == S_DONE) ? id_oh : '0;
    result = result_q;
  end

endmodule

// File: tb/tb_nand_share_arbiter.sv
// Self-checking bench for nand_share_arbiter: transaction-level model plus directed and random stimulus.

module tb_nand_share_arbiter;

  localparam int W = 4;
  localparam int N = 4;

  logic           clk;
  logic           rst_n;
  logic [N-1:0]   req;
  logic [N*W-1:0] op_a;
  logic [N*W-1:0] op_b;
  logic [N-1:0]   gnt;
  logic [N-1:0]   done;
  logic [W-1:0]   result;
  logic           busy;

  int checks = 0;
  int errors = 0;

  nand_share_arbiter #(.WIDTH(W), .NREQ(N)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .req    (req),
    .op_a   (op_a),
    .op_b   (op_b),
    .gnt    (gnt),
    .done   (done),
    .result (result),
    .busy   (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Transaction model: an operation is in flight for two cycles after its grant,
  // the second of which carries done and the fresh result.
  bit         m_active;
  int         m_age;
  int         m_id;
  int         m_ptr;
  logic [W-1:0] m_a, m_b, m_res;

  function automatic int pick(input logic [N-1:0] r, input int p);
    int idx;
`ifdef ARB_ROUND_ROBIN_EN
    for (int k = 1; k <= N; k++) begin
      idx = (p + k) % N;
      if (r[idx[1:0]]) return idx;
    end
`else
    for (int i = 0; i < N; i++) begin
      idx = i;
      if (r[idx[1:0]]) return idx;
    end
`endif
    return 0;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_active = 1'b0;
      m_age    = 0;
      m_id     = 0;
      m_ptr    = N - 1;
      m_a      = '0;
      m_b      = '0;
      m_res    = '0;
    end else if (m_active) begin
      m_age++;
      if (m_age == 1) m_res = ~(m_a & m_b);
      if (m_age == 2) m_active = 1'b0;
    end else if (req != '0) begin
      m_id     = pick(req, m_ptr);
      m_ptr    = m_id;
      m_a      = W'(op_a >> (W * m_id));
      m_b      = W'(op_b >> (W * m_id));
      m_active = 1'b1;
      m_age    = 0;
    end
  end

  function automatic logic [N-1:0] exp_gnt();
    return m_active ? N'(1 << m_id) : '0;
  endfunction

  function automatic logic [N-1:0] exp_done();
    return (m_active && m_age == 1) ? N'(1 << m_id) : '0;
  endfunction

  always @(negedge clk) begin
    check("gnt",    32'(gnt),    32'(exp_gnt()));
    check("done",   32'(done),   32'(exp_done()));
    check("result", 32'(result), 32'(m_res));
    check("busy",   32'(busy),   32'(m_active));
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic serve_all();
    int n;
    n = 0;
    while ((req != '0 || m_active) && n < 100) begin
      if (m_active && m_age == 1) req[m_id[1:0]] = 1'b0;
      tick();
      n++;
    end
    check("serve_all_timeout", 32'(n < 100), 32'd1);
  endtask

  initial begin
    rst_n = 1'b0;
    req   = '0;
    op_a  = '0;
    op_b  = '0;
    tick();
    tick();
    check("rst_gnt",    32'(gnt),    32'h0);
    check("rst_done",   32'(done),   32'h0);
    check("rst_result", 32'(result), 32'h0);
    check("rst_busy",   32'(busy),   32'h0);
    rst_n = 1'b1;
    tick();

    // Single operation on requester 2
    op_a = 16'h0C00;
    op_b = 16'h0A00;
    req  = 4'b0100;
    tick();
    check("single_gnt",  32'(gnt),  32'h4);
    check("single_busy", 32'(busy), 32'h1);
    check("single_done_early", 32'(done), 32'h0);
    tick();
    check("single_done",   32'(done),   32'h4);
    check("single_result", 32'(result), 32'h7);
    req = '0;
    tick();
    check("single_idle_done", 32'(done), 32'h0);
    check("single_idle_busy", 32'(busy), 32'h0);

    // Operands change after capture
    op_a = 16'h000F;
    op_b = 16'h000F;
    req  = 4'b0001;
    tick();
    check("opchg_gnt", 32'(gnt), 32'h1);
    op_a = '0;
    op_b = '0;
    tick();
    check("opchg_done",   32'(done),   32'h1);
    check("opchg_result", 32'(result), 32'h0);
    req = '0;
    tick();

    // Withdrawal of req[2] during EXEC
    req = 4'b0100;
    tick();
    check("wd_gnt", 32'(gnt), 32'h4);
    req = 4'b1001;
    tick();
    check("wd_done", 32'(done), 32'h4);
    tick();
    check("wd_idle", 32'(busy), 32'h0);
    tick();
`ifdef ARB_ROUND_ROBIN_EN
    check("wd_next_gnt", 32'(gnt), 32'h8);
`else
    check("wd_next_gnt", 32'(gnt), 32'h1);
`endif
    serve_all();

    // Contention between requesters 1 and 3
    req = 4'b1010;
    tick();
    check("cont_gnt1", 32'(gnt), 32'h2);
    tick();
    check("cont_done1", 32'(done), 32'h2);
    req = 4'b1000;
    tick();
    check("cont_gap", 32'(busy), 32'h0);
    tick();
    check("cont_gnt3", 32'(gnt), 32'h8);
    tick();
    check("cont_done3", 32'(done), 32'h8);
    req = '0;
    tick();

    // Reset in the middle of EXEC
    req = 4'b0001;
    tick();
    check("mid_gnt", 32'(gnt), 32'h1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_gnt",    32'(gnt),    32'h0);
    check("mid_rst_done",   32'(done),   32'h0);
    check("mid_rst_result", 32'(result), 32'h0);
    check("mid_rst_busy",   32'(busy),   32'h0);
    tick();
    req   = '0;
    rst_n = 1'b1;
    tick();
    tick();
    check("post_rst_done", 32'(done), 32'h0);

    // All four requesters contend from reset: served 0,1,2,3
    req = 4'b1111;
    for (int i = 0; i < N; i++) begin
      tick();
      check("all_gnt", 32'(gnt), 32'(1 << i));
      tick();
      check("all_done", 32'(done), 32'(1 << i));
      req[i] = 1'b0;
      tick();
      check("all_idle", 32'(busy), 32'h0);
    end

    // Randomized traffic checked by the model every cycle
    for (int c = 0; c < 3000; c++) begin
      if (m_active && m_age == 1) req[m_id[1:0]] = 1'b0;
      if (m_active && m_age == 0 && $urandom_range(3) == 0) req[m_id[1:0]] = 1'b0;
      for (int i = 0; i < N; i++) begin
        if (!req[i] && !(m_active && m_id == i) && $urandom_range(3) == 0) req[i] = 1'b1;
      end
      if ($urandom_range(2) == 0) op_a = 16'($urandom);
      if ($urandom_range(2) == 0) op_b = 16'($urandom);
      tick();
    end
    serve_all();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
